mtm_alu_sequencer: RTL

Frame-level controller between the byte deserializer and the ALU core.
- Assembles 8 data bytes plus 1 command byte into B, A and CTL.
- Validates frame length, CRC4 and opcode.
- Issues valid frames to the core, captures the core result and presents one response per frame to the serializer over a valid/ready handshake.
- Invalid frames get an error byte and never reach the core.

---
 rtl/mtm_alu_pkg.sv | 28 ++
 rtl/mtm_alu_crc4_d68.sv | 20 ++
 rtl/mtm_alu_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared constants and types for the MTM ALU frame sequencer.
// Holds the opcode map, error bytes, the FSM state type and the default idle control byte.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic [7:0] ERR_DATA = 8'b1100_1001;
    localparam logic [7:0] ERR_CRC  = 8'b1010_0101;
    localparam logic [7:0] ERR_OP   = 8'b1001_0011;

    localparam logic [7:0] IDLE_CTL_DEFAULT = 8'h80;

    typedef enum logic [2:0] {
        StCollect,
        StCheck,
        StIssue,
        StWait,
        StResp
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mtm_alu_crc4_d68.sv
// Combinational CRC4 (x^4 + x + 1, init 0) over a 68-bit message.
// The message is consumed MSB first, so data[67] is the first serial bit.
module mtm_alu_crc4_d68 (
    input  logic [67:0] data,
    output logic [3:0]  crc
);

    always_comb begin
        logic [3:0] c;
        logic       fb;
        c  = '0;
        fb = 1'b0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ data[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        crc = c;
    end

endmodule

// File: rtl/mtm_alu_sequencer.sv
// Frame-level controller between the byte deserializer and the ALU core.
// Assembles and validates frames, issues good ones to the core and returns one response per frame.
module mtm_alu_sequencer
    import mtm_alu_pkg::*;
#(
    parameter int unsigned CORE_LAT    = 1,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [7:0]  IDLE_CTL    = IDLE_CTL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_is_cmd,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [7:0]  alu_ctl,
    input  logic [31:0] alu_c,
    input  logic [7:0]  alu_ctl_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_c,
    output logic [7:0]  out_ctl,
    output logic        out_is_err
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [ToW-1:0]  to_q, to_d;
    logic [63:0]     ops_q, ops_d;
    logic [2:0]      op_q, op_d;
    logic [3:0]      crc_q, crc_d;
    logic [2:0]      lat_q, lat_d;
    logic [31:0]     out_c_q, out_c_d;
    logic [7:0]      out_ctl_q, out_ctl_d;
    logic            out_err_q, out_err_d;

    logic [3:0]      crc_calc;
    logic            err_hit;
    logic [7:0]      err_byte;
    logic            unused_cmd_msb;

    // Bit 7 of the command byte carries no information.
    assign unused_cmd_msb = in_data[7];

    mtm_alu_crc4_d68 u_crc (
        .data ({ops_q, 1'b1, op_q}),
        .crc  (crc_calc)
    );

    assign alu_b      = ops_q[63:32];
    assign alu_a      = ops_q[31:0];
    assign out_c      = out_c_q;
    assign out_ctl    = out_ctl_q;
    assign out_is_err = out_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        ops_d     = ops_q;
        op_d      = op_q;
        crc_d     = crc_q;
        lat_d     = lat_q;
        out_c_d   = out_c_q;
        out_ctl_d = out_ctl_q;
        out_err_d = out_err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_ctl   = IDLE_CTL;
        err_hit   = 1'b0;
        err_byte  = '0;

        unique case (state_q)
            StCollect: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    to_d = '0;
                    if (in_is_cmd) begin
                        op_d    = in_data[6:4];
                        crc_d   = in_data[3:0];
                        state_d = StCheck;
                    end else begin
                        // Only the first 8 bytes shape the operands; extras just count as overflow.
                        if (cnt_q < 4'd8) begin
                            ops_d = {ops_q[55:0], in_data};
                        end
                        if (cnt_q != 4'd9) begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end else if (cnt_q != 4'd0) begin
                    if (to_q == ToW'(TIMEOUT_CYC - 1)) begin
                        to_d  = '0;
                        cnt_d = '0;
                        ops_d = '0;
                    end else begin
                        to_d = to_q + ToW'(1);
                    end
                end
            end

            StCheck: begin
                cnt_d = '0;
                to_d  = '0;
                if (cnt_q != 4'd8) begin
                    err_hit  = 1'b1;
                    err_byte = ERR_DATA;
                end else if (crc_calc != crc_q) begin
                    err_hit  = 1'b1;
                    err_byte = ERR_CRC;
                end else if (!op_is_legal(op_q)) begin
                    err_hit  = 1'b1;
                    err_byte = ERR_OP;
                end
                if (err_hit) begin
                    out_c_d   = '0;
                    out_ctl_d = err_byte;
                    out_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    state_d = StIssue;
                end
            end

            StIssue: begin
                alu_ctl = {1'b0, op_q, crc_q};
                lat_d   = 3'd1;
                state_d = StWait;
            end

            StWait: begin
                if (lat_q == 3'(CORE_LAT)) begin
                    out_c_d   = alu_c;
                    out_ctl_d = alu_ctl_out;
                    out_err_d = 1'b0;
                    state_d   = StResp;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end

            StResp: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end

            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StCollect;
            cnt_q     <= '0;
            to_q      <= '0;
            ops_q     <= '0;
            op_q      <= '0;
            crc_q     <= '0;
            lat_q     <= '0;
            out_c_q   <= '0;
            out_ctl_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            ops_q     <= ops_d;
            op_q      <= op_d;
            crc_q     <= crc_d;
            lat_q     <= lat_d;
            out_c_q   <= out_c_d;
            out_ctl_q <= out_ctl_d;
            out_err_q <= out_err_d;
        end
    end

endmodule
